cmos_frame_packer: RTL and testbench

Capture-side stage between the OV5640 parallel port and the DDR write FIFO. Samples the 8-bit byte stream on `href`, assembles RGB565 pixels from byte pairs, packs 16 pixels into one 256-bit word and issues a one-cycle write strobe to the DDR frame-buffer FIFO. Capture starts only on a frame boundary after DDR calibration and sensor configuration are done. Per-frame status is reported: pixel/line count checks, frame counter and frame start/done pulses.

---
 rtl/cmos_frame_packer.sv | 211 +++++++++++++++++++++
 tb/tb_cmos_frame_packer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_frame_packer.sv
// OV5640 capture stage: byte pairs -> RGB565 pixels, 16 pixels per 256-bit DDR write word.
// Tracks per-line/per-frame geometry and reports frame boundaries and sticky errors.
`timescale 1ns/1ps
module cmos_frame_packer #(
   parameter int unsigned H_ACTIVE = 1024,
   parameter int unsigned V_ACTIVE = 768,
   parameter logic        VS_POL   = 1'b1
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         init_done,
   input  logic         cam_vsync,
   input  logic         cam_href,
   input  logic [7:0]   cam_data,
   output logic         ddr_wren,
   output logic [255:0] ddr_data,
   output logic         frame_start,
   output logic         frame_done,
   output logic         line_err,
   output logic         frame_err,
   output logic [15:0]  frame_cnt
);

   localparam int unsigned PIX_W    = 16;
   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned IDX_W    = 4;
   localparam int unsigned LINE_W   = 12;
   localparam int unsigned X_W      = 16;
   localparam int unsigned FCNT_W   = 16;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SYNC = 2'd1;
   localparam logic [1:0] S_CAPT = 2'd2;

   logic [1:0]              state;
   logic [1:0]              state_nxt;

   logic                    vs_d;
   logic                    vs_d2;
   logic                    href_d;
   logic                    href_d2;
   logic [BYTE_W-1:0]       data_d;

   logic                    vs_act;
   logic                    href_rise;
   logic                    href_fall;
   logic                    capt;
   logic                    frame_end;
   logic                    line_end;
   logic                    byte_en;
   logic                    cur_phase;
   logic                    pix_done;
   logic                    word_done;
   logic                    frame_start_c;
   logic                    frame_done_c;
   logic [PIX_W-1:0]        pix;

   logic                    phase;
   logic [BYTE_W-1:0]       hi;
   logic [IDX_W-1:0]        pix_idx;
   logic [X_W-1:0]          x_cnt;
   logic [LINE_W-1:0]       line_cnt;
   // Slots 15..1 hold pixels 0..14; pixel 15 goes straight into the committed word.
   logic [15:1][PIX_W-1:0]  acc;

   // Input register stage plus one extra tap for edge detection
   always_ff @(posedge clk) begin
      if (!nrst) begin
         vs_d    <= VS_POL;
         vs_d2   <= VS_POL;
         href_d  <= 1'b0;
         href_d2 <= 1'b0;
         data_d  <= '0;
      end else begin
         vs_d    <= cam_vsync;
         vs_d2   <= vs_d;
         href_d  <= cam_href;
         href_d2 <= href_d;
         data_d  <= cam_data;
      end
   end

   always_comb begin
      vs_act    = (vs_d == VS_POL) && (vs_d2 != VS_POL);
      href_rise = href_d && !href_d2;
      href_fall = !href_d && href_d2;
      capt      = (state == S_CAPT) && init_done;
      frame_end = capt && vs_act;
      // vsync wins over any coincident line activity
      line_end  = capt && href_fall && !vs_act;
      byte_en   = capt && href_d && !vs_act;
      cur_phase = href_rise ? 1'b0 : phase;
      pix_done  = byte_en && cur_phase;
      word_done = pix_done && (pix_idx == IDX_W'(15));
      pix       = {hi, data_d};
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and frame boundary pulses
   always_comb begin
      state_nxt     = state;
      frame_start_c = 1'b0;
      frame_done_c  = 1'b0;
      if (!init_done) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: state_nxt = S_SYNC;
            S_SYNC: begin
               if (vs_act) begin
                  state_nxt     = S_CAPT;
                  frame_start_c = 1'b1;
               end
            end
            S_CAPT: begin
               state_nxt = S_CAPT;
               if (vs_act) begin
                  frame_start_c = 1'b1;
                  frame_done_c  = 1'b1;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Byte pairing, pixel packing and line geometry
   always_ff @(posedge clk) begin
      if (!nrst) begin
         phase    <= 1'b0;
         hi       <= '0;
         pix_idx  <= '0;
         x_cnt    <= '0;
         line_cnt <= '0;
         acc      <= '0;
         ddr_wren <= 1'b0;
         ddr_data <= '0;
      end else begin
         ddr_wren <= 1'b0;
         if (!capt || frame_end) begin
            phase    <= 1'b0;
            pix_idx  <= '0;
            x_cnt    <= '0;
            line_cnt <= '0;
         end else if (line_end) begin
            phase   <= 1'b0;
            pix_idx <= '0;
            x_cnt   <= '0;
            if (line_cnt != '1) begin
               line_cnt <= line_cnt + LINE_W'(1);
            end
         end else if (byte_en) begin
            if (!cur_phase) begin
               hi    <= data_d;
               phase <= 1'b1;
            end else begin
               phase   <= 1'b0;
               pix_idx <= pix_idx + IDX_W'(1);
               if (x_cnt != '1) begin
                  x_cnt <= x_cnt + X_W'(1);
               end
               for (int i = 1; i < 16; i++) begin
                  if (pix_idx == IDX_W'(15 - i)) begin
                     acc[i] <= pix;
                  end
               end
               if (word_done) begin
                  ddr_wren <= 1'b1;
                  ddr_data <= {acc, pix};
               end
            end
         end
      end
   end

   // Frame status: pulses, counter and sticky error flags
   always_ff @(posedge clk) begin
      if (!nrst) begin
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         line_err    <= 1'b0;
         frame_err   <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         frame_start <= frame_start_c;
         frame_done  <= frame_done_c;
         if (frame_end) begin
            frame_cnt <= frame_cnt + FCNT_W'(1);
            if (line_cnt != LINE_W'(V_ACTIVE)) begin
               frame_err <= 1'b1;
            end
         end
         if (line_end && (phase || (pix_idx != '0) || (x_cnt != X_W'(H_ACTIVE)))) begin
            line_err <= 1'b1;
         end
      end
   end

   // Unused pixel-done alias kept readable for the packing condition above
   logic unused_ok;
   assign unused_ok = pix_done;

endmodule

// File: tb/tb_cmos_frame_packer.sv
// Scoreboard bench for cmos_frame_packer: directed frames, expected words/frame status queued
// by the stimulus side and checked by an independent monitor.
`timescale 1ns/1ps
module tb_cmos_frame_packer;

   localparam int H = 32;
   localparam int V = 4;

   typedef struct packed {
      logic [15:0] cnt;
      logic        lerr;
      logic        ferr;
   } fexp_t;

   logic         clk = 1'b0;
   logic         nrst;
   logic         init_done;
   logic         cam_vsync;
   logic         cam_href;
   logic [7:0]   cam_data;
   logic         ddr_wren;
   logic [255:0] ddr_data;
   logic         frame_start;
   logic         frame_done;
   logic         line_err;
   logic         frame_err;
   logic [15:0]  frame_cnt;

   cmos_frame_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .VS_POL(1'b1)) dut (
      .clk(clk), .nrst(nrst), .init_done(init_done),
      .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
      .ddr_wren(ddr_wren), .ddr_data(ddr_data),
      .frame_start(frame_start), .frame_done(frame_done),
      .line_err(line_err), .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [255:0] wq[$];
   fexp_t        fq[$];
   int errors = 0;
   int checks = 0;
   int fs_seen = 0;
   int fs_exp = 0;
   int first_strobe = -1;
   int t32 = -1;
   int pix_base = 0;
   int exp_lines = 0;
   logic exp_lerr = 1'b0;
   logic exp_ferr = 1'b0;
   logic [15:0] exp_fcnt = 16'd0;
   logic [255:0] mon_w;
   fexp_t mon_f;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_reset_values();
      check("rst_wren", 256'(ddr_wren), 256'(0));
      check("rst_data", ddr_data, 256'(0));
      check("rst_fstart", 256'(frame_start), 256'(0));
      check("rst_fdone", 256'(frame_done), 256'(0));
      check("rst_line_err", 256'(line_err), 256'(0));
      check("rst_frame_err", 256'(frame_err), 256'(0));
      check("rst_frame_cnt", 256'(frame_cnt), 256'(0));
   endtask

   // Monitor: pops expectations whenever the DUT presents a strobe or frame end
   always @(negedge clk) begin
      if (frame_start) fs_seen++;
      if (ddr_wren) begin
         if (first_strobe < 0) first_strobe = cyc;
         if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got data %h expected no strobe", ddr_data);
         end else begin
            mon_w = wq.pop_front();
            check("ddr_data", ddr_data, mon_w);
         end
      end
      if (frame_done) begin
         if (fq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_done: got cnt %0d expected no frame_done", frame_cnt);
         end else begin
            mon_f = fq.pop_front();
            check("frame_cnt", 256'(frame_cnt), 256'(mon_f.cnt));
            check("line_err", 256'(line_err), 256'(mon_f.lerr));
            check("frame_err", 256'(frame_err), 256'(mon_f.ferr));
         end
      end
   end

   // One sensor line; pixel i of the frame is 16'h0100+i, high byte first
   task automatic send_line(input int nbytes, input bit cap, input bit term);
      logic [255:0] w;
      logic [15:0]  p;
      int           npix;
      npix = nbytes / 2;
      w = '0;
      if (cap) begin
         for (int k = 0; k < npix; k++) begin
            p = 16'h0100 + 16'(pix_base + k);
            w[255 - 16*(k % 16) -: 16] = p;
            if ((k % 16) == 15) wq.push_back(w);
         end
      end
      for (int b = 0; b < nbytes; b++) begin
         @(negedge clk);
         p = 16'h0100 + 16'(pix_base + b / 2);
         cam_href = 1'b1;
         cam_data = ((b % 2) == 0) ? p[15:8] : p[7:0];
         if (b == 31) t32 = cyc;
      end
      pix_base += npix;
      if (term) begin
         if (cap) begin
            exp_lines++;
            if (nbytes != 2 * H) exp_lerr = 1'b1;
         end
         @(negedge clk);
         cam_href = 1'b0;
         cam_data = 8'h00;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic vsync(input bit start_exp, input bit done_exp);
      fexp_t f;
      if (done_exp) begin
         exp_fcnt = exp_fcnt + 16'd1;
         if (exp_lines != V) exp_ferr = 1'b1;
         f.cnt  = exp_fcnt;
         f.lerr = exp_lerr;
         f.ferr = exp_ferr;
         fq.push_back(f);
      end
      if (start_exp) fs_exp++;
      exp_lines = 0;
      pix_base  = 0;
      @(negedge clk);
      cam_vsync = 1'b1;
      repeat (3) @(negedge clk);
      cam_vsync = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      nrst = 1'b0; init_done = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_values();
      nrst = 1'b1;
      @(negedge clk);
      init_done = 1'b1;
      repeat (3) @(negedge clk);

      // Full frame: 8 words, first word 0x0100..0x010F
      vsync(1'b1, 1'b0);
      for (int i = 0; i < V; i++) begin
         send_line(2 * H, 1'b1, 1'b1);
         if (i == 0) check("strobe_latency", 256'(first_strobe), 256'(t32 + 2));
      end
      vsync(1'b1, 1'b1);

      // init_done low then raised mid-frame: nothing captured until next vsync
      init_done = 1'b0;
      send_line(2 * H, 1'b0, 1'b1);
      send_line(2 * H, 1'b0, 1'b1);
      init_done = 1'b1;
      send_line(2 * H, 1'b0, 1'b1);
      send_line(2 * H, 1'b0, 1'b1);
      vsync(1'b1, 1'b0);
      for (int i = 0; i < V; i++) send_line(2 * H, 1'b1, 1'b1);
      vsync(1'b1, 1'b1);

      // Odd, short line: one word only, line_err set
      send_line(63, 1'b1, 1'b1);
      for (int i = 1; i < V; i++) send_line(2 * H, 1'b1, 1'b1);
      vsync(1'b1, 1'b1);

      // Short frame: frame_err set
      for (int i = 0; i < V - 1; i++) send_line(2 * H, 1'b1, 1'b1);
      vsync(1'b1, 1'b1);

      // Reset after the 20th byte of line 2
      send_line(2 * H, 1'b1, 1'b1);
      send_line(2 * H, 1'b1, 1'b1);
      send_line(20, 1'b1, 1'b0);
      @(negedge clk);
      nrst = 1'b0;
      cam_href = 1'b0;
      cam_data = 8'h00;
      @(negedge clk);
      nrst = 1'b1;
      check_reset_values();
      exp_lerr = 1'b0; exp_ferr = 1'b0; exp_fcnt = 16'd0; exp_lines = 0; pix_base = 0;
      send_line(2 * H, 1'b0, 1'b1);
      vsync(1'b1, 1'b0);
      for (int i = 0; i < V; i++) send_line(2 * H, 1'b1, 1'b1);
      vsync(1'b1, 1'b1);

      // frame_cnt wrap 0xFFFF -> 0
      force dut.frame_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt;
      exp_fcnt = 16'hFFFF;
      for (int i = 0; i < V; i++) send_line(2 * H, 1'b1, 1'b1);
      vsync(1'b1, 1'b1);

      repeat (10) @(negedge clk);
      check("words_pending", 256'(wq.size()), 256'(0));
      check("frames_pending", 256'(fq.size()), 256'(0));
      check("frame_start_count", 256'(fs_seen), 256'(fs_exp));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
